// File: rtl/trend_pkg.sv
// Shared types, parameter defaults and sample-classification helpers for the trend tracker.
package trend_pkg;

    localparam int RUN_LEN_DEF   = 4;
    localparam int ERR_LIMIT_DEF = 3;
    localparam int CNT_W_DEF     = 8;
    localparam int RUN_W         = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RISE  = 2'd1,
        FALL  = 2'd2,
        FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2,
        ERR  = 2'd3
    } kind_t;

    // Any combination other than a single incr or a single decr counts as an error sample.
    function automatic kind_t classify(input logic incr, input logic decr, input logic error);
        case ({incr, decr, error})
            3'b000:  return NONE;
            3'b100:  return UP;
            3'b010:  return DN;
            default: return ERR;
        endcase
    endfunction

    function automatic logic multi_flag(input logic incr, input logic decr, input logic error);
        return (incr & decr) | (incr & error) | (decr & error);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones, with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {width{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/trend_tracker.sv
// Classifies step flags into UP/DN/ERR samples, tracks run length and a
// RISE/FALL/FAULT trend, and keeps saturating per-kind sample totals.
module trend_tracker
    import trend_pkg::*;
#(
    parameter int RUN_LEN   = RUN_LEN_DEF,
    parameter int ERR_LIMIT = ERR_LIMIT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             incr,
    input  logic             decr,
    input  logic             error,
    input  logic             clear,
    output logic             trend_up,
    output logic             trend_down,
    output logic             fault,
    output logic             illegal,
    output logic [RUN_W-1:0] run_cnt,
    output logic [CNT_W-1:0] incr_total,
    output logic [CNT_W-1:0] decr_total,
    output logic [CNT_W-1:0] err_total
);

    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

    state_t           state;
    state_t           state_next;
    kind_t            prev_kind;
    kind_t            kind;
    logic             sample;
    logic             multi;
    logic [RUN_W-1:0] run_next;
    logic             up_hit;
    logic             dn_hit;
    logic             err_hit;

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        sample   = in_valid && (incr || decr || error);
        kind     = classify(incr, decr, error);
        multi    = multi_flag(incr, decr, error);
        run_next = RUN_W'(1);
        if (kind == prev_kind) begin
            run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
        end
        up_hit  = (kind == UP)  && (run_next >= RUN_W'(RUN_LEN));
        dn_hit  = (kind == DN)  && (run_next >= RUN_W'(RUN_LEN));
        err_hit = (kind == ERR) && (run_next >= RUN_W'(ERR_LIMIT));
    end

    // Transitions are judged on the run length this sample produces, not the stored one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (up_hit)       state_next = RISE;
                else if (dn_hit)  state_next = FALL;
                else if (err_hit) state_next = FAULT;
            end
            RISE: begin
                if (kind != UP) begin
                    if (dn_hit)       state_next = FALL;
                    else if (err_hit) state_next = FAULT;
                    else              state_next = IDLE;
                end
            end
            FALL: begin
                if (kind != DN) begin
                    if (up_hit)       state_next = RISE;
                    else if (err_hit) state_next = FAULT;
                    else              state_next = IDLE;
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            prev_kind  <= NONE;
            run_cnt    <= '0;
            illegal    <= 1'b0;
            trend_up   <= 1'b0;
            trend_down <= 1'b0;
            fault      <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            prev_kind  <= NONE;
            run_cnt    <= '0;
            illegal    <= 1'b0;
            trend_up   <= 1'b0;
            trend_down <= 1'b0;
            fault      <= 1'b0;
        end else if (sample) begin
            state      <= state_next;
            prev_kind  <= kind;
            run_cnt    <= run_next;
            illegal    <= multi;
            trend_up   <= (state_next == RISE);
            trend_down <= (state_next == FALL);
            fault      <= (state_next == FAULT);
        end else begin
            illegal    <= 1'b0;
        end
    end

    sat_counter #(.width(CNT_W)) u_incr_total (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (sample && (kind == UP)),
        .count (incr_total)
    );

    sat_counter #(.width(CNT_W)) u_decr_total (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (sample && (kind == DN)),
        .count (decr_total)
    );

    sat_counter #(.width(CNT_W)) u_err_total (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (sample && (kind == ERR)),
        .count (err_total)
    );

endmodule

// File: tb/tb_trend_tracker.sv
// Scoreboard bench for trend_tracker: a behavioural model pushes expected outputs per
// driven cycle, which are popped and compared one clock edge later.
module tb_trend_tracker;

    localparam int CNT_W   = 8;
    localparam int TOT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             incr = 1'b0;
    logic             decr = 1'b0;
    logic             error = 1'b0;
    logic             clear = 1'b0;
    logic             trend_up;
    logic             trend_down;
    logic             fault;
    logic             illegal;
    logic [3:0]       run_cnt;
    logic [CNT_W-1:0] incr_total;
    logic [CNT_W-1:0] decr_total;
    logic [CNT_W-1:0] err_total;

    trend_tracker #(.RUN_LEN(4), .ERR_LIMIT(3), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .incr       (incr),
        .decr       (decr),
        .error      (error),
        .clear      (clear),
        .trend_up   (trend_up),
        .trend_down (trend_down),
        .fault      (fault),
        .illegal    (illegal),
        .run_cnt    (run_cnt),
        .incr_total (incr_total),
        .decr_total (decr_total),
        .err_total  (err_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tu; int td; int fl; int il; int run; int it; int dt; int et;
    } exp_t;

    exp_t sb[$];

    // Model state: 0 idle, 1 rise, 2 fall, 3 fault; kinds 0 none, 1 up, 2 dn, 3 err.
    int m_state, m_prev, m_run, m_it, m_dt, m_et, m_ill;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_run = 0; m_it = 0; m_dt = 0; m_et = 0; m_ill = 0;
    endtask

    task automatic model_step(input bit v, input bit i, input bit d, input bit e, input bit c);
        int nf, k;
        bit upr, dnr, errr;
        nf = int'(i) + int'(d) + int'(e);
        if (c) begin
            model_reset();
        end else if (v && nf > 0) begin
            k     = (nf > 1) ? 3 : (i ? 1 : (d ? 2 : 3));
            m_ill = (nf > 1) ? 1 : 0;
            m_run = (k == m_prev) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
            m_prev = k;
            if (k == 1 && m_it < TOT_MAX) m_it++;
            if (k == 2 && m_dt < TOT_MAX) m_dt++;
            if (k == 3 && m_et < TOT_MAX) m_et++;
            upr  = (k == 1) && (m_run >= 4);
            dnr  = (k == 2) && (m_run >= 4);
            errr = (k == 3) && (m_run >= 3);
            if (m_state != 3 && !(m_state == 1 && k == 1) && !(m_state == 2 && k == 2)) begin
                if (upr)       m_state = 1;
                else if (dnr)  m_state = 2;
                else if (errr) m_state = 3;
                else           m_state = 0;
            end
        end else begin
            m_ill = 0;
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("trend_up",   32'(trend_up),   32'(e.tu));
        check("trend_down", 32'(trend_down), 32'(e.td));
        check("fault",      32'(fault),      32'(e.fl));
        check("illegal",    32'(illegal),    32'(e.il));
        check("run_cnt",    32'(run_cnt),    32'(e.run));
        check("incr_total", 32'(incr_total), 32'(e.it));
        check("decr_total", 32'(decr_total), 32'(e.dt));
        check("err_total",  32'(err_total),  32'(e.et));
    endtask

    task automatic drive(input bit v, input bit i, input bit d, input bit e, input bit c);
        exp_t x;
        @(negedge clk);
        in_valid = v; incr = i; decr = d; error = e; clear = c;
        model_step(v, i, d, e, c);
        x.tu = (m_state == 1) ? 1 : 0;
        x.td = (m_state == 2) ? 1 : 0;
        x.fl = (m_state == 3) ? 1 : 0;
        x.il = m_ill; x.run = m_run; x.it = m_it; x.dt = m_dt; x.et = m_et;
        sb.push_back(x);
        @(posedge clk);
        #1;
        compare_out();
        in_valid = 1'b0; incr = 1'b0; decr = 1'b0; error = 1'b0; clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {trend_up, trend_down, fault, illegal, run_cnt,
                    8'(incr_total), 8'(decr_total), 8'(err_total)}, 32'd0);
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        reset = 1'b1;

        // Rising run confirmed on the fourth incr sample.
        repeat (4) drive(1, 1, 0, 0, 0);
        check("rise_trend_up", 32'(trend_up), 32'd1);
        check("rise_run_cnt", 32'(run_cnt), 32'd4);
        check("rise_incr_total", 32'(incr_total), 32'd4);

        // One decr drops back to IDLE, three more confirm FALL.
        drive(1, 0, 1, 0, 0);
        check("drop_trend_up", 32'(trend_up), 32'd0);
        check("drop_run_cnt", 32'(run_cnt), 32'd1);
        repeat (3) drive(1, 0, 1, 0, 0);
        check("fall_trend_down", 32'(trend_down), 32'd1);

        // FAULT is sticky across incr samples until clear.
        drive(1, 0, 0, 0, 1);
        repeat (3) drive(1, 0, 0, 1, 0);
        check("fault_set", 32'(fault), 32'd1);
        repeat (5) drive(1, 1, 0, 0, 0);
        check("fault_sticky", 32'(fault), 32'd1);
        check("fault_incr_total", 32'(incr_total), 32'd5);
        drive(0, 0, 0, 0, 1);
        check_all_zero("clear_all_zero");

        // Multi-flag sample pulses illegal once; idle cycles with flags but no valid hold state.
        drive(1, 1, 1, 0, 0);
        check("illegal_pulse", 32'(illegal), 32'd1);
        check("illegal_err_total", 32'(err_total), 32'd1);
        drive(0, 1, 0, 0, 0);
        check("illegal_drop", 32'(illegal), 32'd0);
        drive(0, 0, 1, 1, 0);
        drive(1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        check("gap_run_cnt", 32'(run_cnt), 32'd2);
        drive(1, 1, 0, 1, 0);
        drive(1, 0, 1, 1, 0);
        drive(1, 1, 1, 1, 0);
        check("multi_err_run", 32'(run_cnt), 32'd3);
        check("multi_fault", 32'(fault), 32'd1);

        // Clear beats a simultaneous sample.
        drive(1, 0, 1, 0, 1);
        check("clear_wins_decr", 32'(decr_total), 32'd0);
        check("clear_wins_state", {30'd0, trend_down, fault}, 32'd0);

        // Saturation of totals and run_cnt.
        repeat (300) drive(1, 1, 0, 0, 0);
        check("sat_incr_total", 32'(incr_total), 32'd255);
        check("sat_run_cnt", 32'(run_cnt), 32'd15);

        // Asynchronous reset mid-run, sampled away from any clock edge.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1, 0, 0, 0);
        check("post_reset_run", 32'(run_cnt), 32'd1);

        // Random mix with occasional clears.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 39) == 0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trend_tracker.md
TREND_TRACKER -- requirements
Module: trend_tracker

Interface
REQ-001 Parameters (name, default, meaning): RUN_LEN, 4, consecutive same-direction samples confirming a trend (1..15).
REQ-002 ERR_LIMIT, 3, consecutive error samples entering FAULT (1..15).
REQ-003 CNT_W, 8, width of the total counters.
REQ-004 Ports (name, direction, width, meaning): clk, in, 1, single clock, rising edge.
REQ-005 reset, in, 1, asynchronous active-low reset.
REQ-006 in_valid, in, 1, flag sample present this cycle.
REQ-007 incr, in, 1, upstream step-up flag.
REQ-008 decr, in, 1, upstream step-down flag.
REQ-009 error, in, 1, upstream non-unit-step flag.
REQ-010 clear, in, 1, synchronous clear of FAULT and totals.
REQ-011 trend_up, out, 1, state is RISE.
REQ-012 trend_down, out, 1, state is FALL.
REQ-013 fault, out, 1, state is FAULT.
REQ-014 illegal, out, 1, one-cycle pulse: last sample had more than one flag set.
REQ-015 run_cnt, out, 4, length of the current same-kind run, saturating at 15.
REQ-016 incr_total, decr_total, err_total, out, CNT_W each, saturating per-kind sample counts.

Function
REQ-017 Only cycles with in_valid=1 and at least one flag set shall be samples; all other cycles hold all state and drop illegal.
REQ-018 Sample kind: UP if only incr is set; DN if only decr is set; ERR if only error is set or if two or more flags are set.
REQ-019 A multi-flag sample shall pulse illegal for exactly one cycle.
REQ-020 All outputs shall be registered; a sample is reflected on every output on the first clk edge after it is presented (1-cycle latency).
REQ-021 run_cnt shall increment (saturating) when the sample kind equals the previous kind; otherwise it shall load 1.
REQ-022 States: IDLE, RISE, FALL, FAULT. Next-state transitions are evaluated on the updated run_cnt.
REQ-023 IDLE: UP run reaching RUN_LEN goes to RISE; DN run reaching RUN_LEN goes to FALL; ERR run reaching ERR_LIMIT goes to FAULT.
REQ-024 RISE: UP holds. DN or ERR returns to IDLE, unless the same sample satisfies a REQ-023 condition, which takes effect directly.
REQ-025 FALL: symmetric to RISE with UP and DN swapped.
REQ-026 FAULT: sticky on every sample; totals and run_cnt continue updating.
REQ-027 Totals shall each increment by 1 per sample of their kind and saturate at all-ones with no wrap.
REQ-028 clear=1 shall zero the totals and run_cnt, force IDLE, and drop illegal; any sample presented in that same cycle is discarded (clear wins).

Reset
REQ-029 While reset=0: state IDLE, and all outputs and the previous-kind register are 0, asynchronously and regardless of clk.
REQ-030 Deassertion mid-stream shall restart tracking from IDLE with run_cnt=0; the first sample after reset always loads run_cnt=1.

Structure
REQ-031 The state typedef, the sample-kind typedef (NONE/UP/DN/ERR) and the parameter defaults shall live in package trend_pkg.
REQ-032 The saturating counter shall be sub-module sat_counter (parameter width; ports clk, reset, clr, inc, count), instantiated three times.

Verification (RUN_LEN=4, ERR_LIMIT=3, CNT_W=8)
REQ-033 4 consecutive incr samples -> trend_up=1 one cycle after the 4th sample; run_cnt=4; incr_total=4.
REQ-034 In RISE, 1 decr sample -> IDLE, trend_up=0, run_cnt=1; 3 further decr samples -> trend_down=1.
REQ-035 3 error samples, then 5 incr samples -> fault stays 1, incr_total=5; clear pulse -> fault=0, all totals 0, run_cnt=0.
REQ-036 Sample with incr=decr=1 -> illegal pulses for 1 cycle, err_total=1; in_valid=0 cycles between samples change nothing.
REQ-037 300 incr samples -> incr_total=255 with no wrap and run_cnt=15; reset=0 asserted mid-run -> all outputs 0 immediately, without waiting for a clk edge.
REQ-038 clear and a decr sample in the same cycle -> decr_total=0 and state IDLE on the next cycle.
